led_message_scroller: RTL and testbench

LED_MESSAGE_SCROLLER -- requirements
Module: led_message_scroller

---
 rtl/led_pkg.sv | 25 ++
 rtl/scroll_tick_gen.sv | 39 +++
 rtl/led_message_scroller.sv | 110 +++++++++++
 tb/tb_led_message_scroller.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared types and constants for the LED message scroller.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int MSG_LEN  = 16;
    localparam int c_CHAR_W = 4;
    localparam int c_PTR_W  = 4;

    typedef logic [c_CHAR_W-1:0] char_t;
    typedef logic [c_PTR_W-1:0]  ptr_t;

    localparam logic [0:0] c_ST_RUN  = 1'b0;
    localparam logic [0:0] c_ST_HOLD = 1'b1;

    typedef enum logic [0:0] {
        ST_RUN  = c_ST_RUN,
        ST_HOLD = c_ST_HOLD
    } state_t;

endpackage
`default_nettype wire

// File: rtl/scroll_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : scroll_tick_gen
// Description : Prescaler counting 0..PERIOD-1; tick marks the terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module scroll_tick_gen #(
    parameter int PERIOD = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int c_CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(PERIOD - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_count;

    // Count holds its value while disabled so a paused scroll resumes mid-period.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable) begin
            if (r_count == c_LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + c_ONE;
            end
        end
    end

    assign tick = enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/led_message_scroller.sv
`default_nettype none
// ============================================================================
// Module      : led_message_scroller
// Description : Scrolls a four-character window over a 16-entry message store.
// Revision    : 1.0 - initial release
// ============================================================================
module led_message_scroller #(
    parameter int SCROLL_PERIOD = 50_000_000,
    parameter int MSG_LEN       = led_pkg::MSG_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pause,
    input  logic       restart,
    input  logic       load_valid,
    input  logic [3:0] load_addr,
    input  logic [3:0] load_data,
    output logic       load_ready,
    output logic [3:0] char3,
    output logic [3:0] char2,
    output logic [3:0] char1,
    output logic [3:0] char0,
    output logic       step_pulse
);

    import led_pkg::*;

    state_t r_state;
    state_t w_state_next;
    ptr_t   r_ptr;
    logic   r_step;
    logic   w_tick;
    logic   w_advance;
    logic   w_wr_en;
    ptr_t   w_idx1;
    ptr_t   w_idx2;
    ptr_t   w_idx3;
    char_t  r_msg [MSG_LEN];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:  if (pause)  w_state_next = ST_HOLD;
            ST_HOLD: if (!pause) w_state_next = ST_RUN;
            default: w_state_next = ST_RUN;
        endcase
    end

    scroll_tick_gen #(
        .PERIOD (SCROLL_PERIOD)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (r_state == ST_RUN),
        .clear  (restart),
        .tick   (w_tick)
    );

    // A restart wins over a terminal count on the same edge.
    assign w_advance = w_tick && !restart;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr  <= '0;
            r_step <= 1'b0;
        end else begin
            r_step <= w_advance;
            if (restart) begin
                r_ptr <= '0;
            end else if (w_advance) begin
                r_ptr <= r_ptr + ptr_t'(1);
            end
        end
    end

    assign load_ready = (r_state == ST_HOLD) && !reset;
    assign w_wr_en    = load_valid && load_ready;

    generate
        for (genvar gi = 0; gi < MSG_LEN; gi++) begin : g_msg
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_msg[gi] <= char_t'(gi);
                end else if (w_wr_en && (load_addr == ptr_t'(gi))) begin
                    r_msg[gi] <= load_data;
                end
            end
        end
    endgenerate

    assign w_idx1 = r_ptr + ptr_t'(1);
    assign w_idx2 = r_ptr + ptr_t'(2);
    assign w_idx3 = r_ptr + ptr_t'(3);

    assign char3      = r_msg[r_ptr];
    assign char2      = r_msg[w_idx1];
    assign char1      = r_msg[w_idx2];
    assign char0      = r_msg[w_idx3];
    assign step_pulse = r_step;

endmodule
`default_nettype wire

// File: tb/tb_led_message_scroller.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_message_scroller
// Description : Directed self-checking bench for led_message_scroller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_message_scroller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pause = 1'b0;
    logic        restart = 1'b0;
    logic        load_valid = 1'b0;
    logic [3:0]  load_addr = 4'd0;
    logic [3:0]  load_data = 4'd0;
    logic        w_load_ready;
    logic [3:0]  w_char3, w_char2, w_char1, w_char0;
    logic        w_step_pulse;
    logic [15:0] w_chars;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses;

    always #5 clk = ~clk;

    led_message_scroller #(
        .SCROLL_PERIOD (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pause      (pause),
        .restart    (restart),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_ready (w_load_ready),
        .char3      (w_char3),
        .char2      (w_char2),
        .char1      (w_char1),
        .char0      (w_char0),
        .step_pulse (w_step_pulse)
    );

    assign w_chars = {w_char3, w_char2, w_char1, w_char0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance n edges, counting step_pulse samples along the way.
    task automatic run(input int n);
        n_pulses = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (w_step_pulse) n_pulses++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state and first step
        do_reset();
        chk("rst_chars", w_chars, 16'h0123);
        chk("rst_ready", w_load_ready, 0);
        chk("rst_pulse", w_step_pulse, 0);
        run(3);
        chk("pre_step_pulses", n_pulses, 0);
        step();
        chk("step1_pulse", w_step_pulse, 1);
        chk("step1_chars", w_chars, 16'h1234);
        step();
        chk("step1_pulse_clr", w_step_pulse, 0);

        // Wrap around the message
        do_reset();
        run(52);
        chk("wrap13_pulses", n_pulses, 13);
        chk("wrap13_chars", w_chars, 16'hDEF0);
        run(12);
        chk("wrap16_chars", w_chars, 16'h0123);

        // Pause freezes the prescaler mid-count
        do_reset();
        run(2);
        pause = 1'b1;
        run(20);
        chk("hold_pulses", n_pulses, 0);
        chk("hold_chars", w_chars, 16'h0123);
        chk("hold_ready", w_load_ready, 1);
        pause = 1'b0;
        step();
        chk("resume_pulse1", w_step_pulse, 0);
        step();
        chk("resume_pulse2", w_step_pulse, 1);
        chk("resume_chars", w_chars, 16'h1234);

        // Writes accepted only in HOLD
        do_reset();
        pause = 1'b1;
        step();
        load_valid = 1'b1; load_addr = 4'd1; load_data = 4'd9;
        #1;
        chk("wr_ready", w_load_ready, 1);
        step();
        load_valid = 1'b0;
        chk("wr_chars", w_chars, 16'h0923);
        pause = 1'b0;
        step();
        load_valid = 1'b1; load_addr = 4'd2; load_data = 4'd7;
        #1;
        chk("run_ready", w_load_ready, 0);
        step();
        load_valid = 1'b0;
        chk("run_wr_ignored", w_chars, 16'h0923);

        // Restart on the terminal-count edge
        do_reset();
        run(20);
        chk("pre_restart_chars", w_chars, 16'h5678);
        run(3);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_chars", w_chars, 16'h0123);
        chk("restart_pulse", w_step_pulse, 0);
        run(3);
        chk("restart_clr_pulses", n_pulses, 0);
        step();
        chk("restart_next_step", w_chars, 16'h1234);

        // Coincident write and restart in HOLD, then reset mid-HOLD
        do_reset();
        run(4);
        pause = 1'b1;
        step();
        restart = 1'b1;
        load_valid = 1'b1; load_addr = 4'd0; load_data = 4'hA;
        step();
        restart = 1'b0;
        chk("wr_restart_chars", w_chars, 16'hA123);
        load_addr = 4'd3; load_data = 4'hC;
        step();
        chk("wr2_chars", w_chars, 16'hA12C);
        load_addr = 4'd2; load_data = 4'hF;
        reset = 1'b1;
        #1;
        chk("ready_in_reset", w_load_ready, 0);
        step();
        reset = 1'b0;
        load_valid = 1'b0;
        pause = 1'b0;
        #1;
        chk("hold_rst_chars", w_chars, 16'h0123);
        chk("hold_rst_ready", w_load_ready, 0);
        chk("hold_rst_pulse", w_step_pulse, 0);
        run(4);
        chk("hold_rst_running", w_chars, 16'h1234);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
